// File: rtl/seg7_pkg.sv
// Seven-segment constants shared by the scanner and the clock block.
// Patterns are active low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_D0 = 7'b1000000;
    localparam logic [6:0] SEG_D1 = 7'b1111001;
    localparam logic [6:0] SEG_D2 = 7'b0100100;
    localparam logic [6:0] SEG_D3 = 7'b0110000;
    localparam logic [6:0] SEG_D4 = 7'b0011001;
    localparam logic [6:0] SEG_D5 = 7'b0010010;
    localparam logic [6:0] SEG_D6 = 7'b0000010;
    localparam logic [6:0] SEG_D7 = 7'b1111000;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0010000;

    // Same encoding the clock block uses for its setup location.
    localparam logic [1:0] IDX_HOUR_UPPER   = 2'd0;
    localparam logic [1:0] IDX_HOUR_LOWER   = 2'd1;
    localparam logic [1:0] IDX_MINUTE_UPPER = 2'd2;
    localparam logic [1:0] IDX_MINUTE_LOWER = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low segment pattern; 10..15 render as a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (val_i)
            4'd0: seg_o = SEG_D0;
            4'd1: seg_o = SEG_D1;
            4'd2: seg_o = SEG_D2;
            4'd3: seg_o = SEG_D3;
            4'd4: seg_o = SEG_D4;
            4'd5: seg_o = SEG_D5;
            4'd6: seg_o = SEG_D6;
            4'd7: seg_o = SEG_D7;
            4'd8: seg_o = SEG_D8;
            4'd9: seg_o = SEG_D9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode driver; all outputs registered one cycle
// behind the selected digit, with the edited digit blinking during setup.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup_mode,
    input  logic [1:0] loc,
    input  logic [3:0] hour_upper,
    input  logic [3:0] hour_lower,
    input  logic [3:0] minute_upper,
    input  logic [3:0] minute_lower,
    input  logic [5:0] second_count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         scan_idx_q, scan_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic [3:0] digit_sel;
    logic [3:0] an_sel;
    logic [6:0] seg_dec;
    logic       scan_tc, blink_tc, blank;

    seg7_decode u_decode (
        .val_i (digit_sel),
        .seg_o (seg_dec)
    );

    always_comb begin
        digit_sel = hour_upper;
        an_sel    = 4'b0111;
        case (scan_idx_q)
            IDX_HOUR_UPPER:   begin digit_sel = hour_upper;   an_sel = 4'b0111; end
            IDX_HOUR_LOWER:   begin digit_sel = hour_lower;   an_sel = 4'b1011; end
            IDX_MINUTE_UPPER: begin digit_sel = minute_upper; an_sel = 4'b1101; end
            IDX_MINUTE_LOWER: begin digit_sel = minute_lower; an_sel = 4'b1110; end
            default:          begin digit_sel = hour_upper;   an_sel = 4'b0111; end
        endcase
    end

    always_comb begin
        scan_tc  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        blink_tc = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

        scan_cnt_d    = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
        scan_idx_d    = scan_tc ? scan_idx_q + 2'd1 : scan_idx_q;
        blink_cnt_d   = blink_tc ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_tc ? ~blink_phase_q : blink_phase_q;

        // The digit being edited disappears during the "off" half of the blink.
        blank = setup_mode && blink_phase_q && (loc == scan_idx_q);
        an_d  = blank ? 4'b1111 : an_sel;
        seg_d = blank ? SEG_BLANK : seg_dec;
        // Colon sits on the hour-lower digit and is suppressed while setting time.
        dp_d  = !((scan_idx_q == IDX_HOUR_LOWER) && !setup_mode && !second_count[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            scan_idx_q    <= IDX_HOUR_UPPER;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed and random inputs checked against a
// time-based model (output after edge n reflects digit ((n-1)/SCAN_DIV) mod 4).
module tb_seven_seg_scanner;

    localparam int SD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       setup_mode = 1'b0;
    logic [1:0] loc = 2'd0;
    logic [3:0] hour_upper = 4'd0, hour_lower = 4'd0, minute_upper = 4'd0, minute_lower = 4'd0;
    logic [5:0] second_count = 6'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    seven_seg_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .setup_mode   (setup_mode),
        .loc          (loc),
        .hour_upper   (hour_upper),
        .hour_lower   (hour_lower),
        .minute_upper (minute_upper),
        .minute_lower (minute_lower),
        .second_count (second_count),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Edge count n restarts at every reset; inputs are held across each edge.
    task automatic tick();
        @(posedge clk);
        if (rst) n = 0;
        else     n++;
        #1;
    endtask

    task automatic check_model(input string tag);
        int idx;
        bit ph, blank;
        logic [3:0] d, onehot, exp_an;
        logic [6:0] exp_seg;
        logic exp_dp;
        idx = ((n - 1) / SD) % 4;
        ph  = (((n - 1) / BD) % 2) == 1;
        case (idx)
            0: d = hour_upper;
            1: d = hour_lower;
            2: d = minute_upper;
            default: d = minute_lower;
        endcase
        blank   = setup_mode && ph && (int'(loc) == idx);
        onehot  = 4'b1000 >> idx;
        exp_an  = blank ? 4'b1111 : ~onehot;
        exp_seg = blank ? 7'h7F : pat[d];
        exp_dp  = !(idx == 1 && !setup_mode && !second_count[0]);
        chk({tag, ".an"}, {3'b0, an}, {3'b0, exp_an});
        chk({tag, ".seg"}, seg, exp_seg);
        chk({tag, ".dp"}, {6'b0, dp}, {6'b0, exp_dp});
    endtask

    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check_model(tag);
        end
    endtask

    task automatic do_reset(input int cycles, input string tag);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk({tag, ".an"}, {3'b0, an}, 7'h0F);
            chk({tag, ".seg"}, seg, 7'h7F);
            chk({tag, ".dp"}, {6'b0, dp}, 7'h01);
        end
        rst = 1'b0;
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
        hour_upper = a; hour_lower = b; minute_upper = c; minute_lower = e;
    endtask

    initial begin
        // Reset with arbitrary inputs driven.
        set_digits(4'd7, 4'd5, 4'd9, 4'd2);
        setup_mode = 1'b1; loc = 2'd0; second_count = 6'd0;
        do_reset(3, "reset");

        // Scan order 1,2,3,4 and colon with even seconds.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        setup_mode = 1'b0; second_count = 6'd10;
        tick();
        chk("first_digit.an", {3'b0, an}, 7'h07);
        check_model("first_digit");
        run(31, "scan_even");

        // Odd seconds: colon stays dark.
        second_count = 6'd11;
        run(16, "scan_odd");

        // Setup blink on minute_upper.
        setup_mode = 1'b1; loc = 2'd2; second_count = 6'd10;
        run(48, "blink_loc2");

        // Out-of-range digit shows a dash.
        setup_mode = 1'b0;
        set_digits(4'd0, 4'd8, 4'd9, 4'hC);
        run(16, "dash");

        // Mid-scan reset at scan_idx=2, scan_cnt=1 (nine edges after release).
        do_reset(1, "pre_mid");
        run(9, "pre_mid_run");
        do_reset(1, "mid_reset");
        for (int i = 0; i < SD; i++) begin
            tick();
            chk("post_reset_dwell.an", {3'b0, an}, 7'h07);
        end
        tick();
        chk("post_reset_next.an", {3'b0, an}, 7'h0B);

        // Random inputs, including loc/setup changes landing on arbitrary cycles.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) setup_mode = 1'($urandom);
            if ($urandom_range(0, 5) == 0) loc = 2'($urandom);
            set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            second_count = 6'($urandom);
            tick();
            check_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed 4-digit seven-segment display driver.
- Sits directly downstream of the clock/time-keeping block.
- Consumes its BCD hour/minute digits, seconds count, setup-mode flag and setup digit location.
- Drives the board's common-anode display: active-low anodes, segments and decimal point.
- In setup mode, the digit under edit blinks.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays selected (1 kHz per digit at 50 MHz).
- BLINK_DIV, 12500000, clk cycles per blink half-period (0.25 s at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- setup_mode  in  1  1 = time being set; enables blinking
- loc  in  2  digit under edit in setup: 0=hour_upper, 1=hour_lower, 2=minute_upper, 3=minute_lower
- hour_upper  in  4  BCD digit
- hour_lower  in  4  BCD digit
- minute_upper  in  4  BCD digit
- minute_lower  in  4  BCD digit
- second_count  in  6  running seconds; bit 0 drives the colon DP
- an  out  4  anode enables, active low; an[3]=hour_upper … an[0]=minute_lower
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low

Behaviour:
- One clock domain; reset is synchronous, active-high.
- All outputs are registered. Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1
  - scan_cnt=0, scan_idx=0, blink_cnt=0, blink_phase=0
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On the cycle scan_cnt==SCAN_DIV-1, scan_idx advances 0→1→2→3→0. scan_idx 3 wraps to 0; there is no idle state.
- Digit mapping, scan_idx to anode and source:
  - 0 → an[3], hour_upper
  - 1 → an[2], hour_lower
  - 2 → an[1], minute_upper
  - 3 → an[0], minute_lower
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1 and wraps.
  - blink_phase toggles on the terminal count.
  - The blink counter runs regardless of setup_mode.
- Output register update, every cycle, from the current scan_idx and current inputs:
  - an: exactly one bit low (the selected digit), unless that digit is blanked.
  - Blank condition: setup_mode=1, blink_phase=1 and loc==scan_idx. When blanked, an=4'b1111 and seg=7'b1111111.
  - seg: decode of the selected digit.
    - 0..9 use standard patterns (0=7'b1000000, 1=7'b1111001, 8=7'b0000000).
    - 10..15 show a dash, 7'b0111111.
  - dp: 0 only when scan_idx==1, setup_mode==0 and second_count[0]==0. This gives a colon blinking at 0.5 Hz. Otherwise dp=1.
- Latency:
  - An input digit change appears on seg one cycle later, provided that digit is selected.
  - A scan_idx advance appears on an the cycle after the terminal count.
- Simultaneous events:
  - Scan and blink terminal counts on the same cycle are both applied.
  - A setup_mode or loc change takes effect on the next output register update.
- Reset mid-scan: the next cycle returns outputs to reset values. Scanning restarts at idx 0 with a full SCAN_DIV dwell.
- The block does not validate BCD range beyond the dash substitution. It never drives two anodes low simultaneously.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F
  - digit-pattern constants 0..9
  - digit index constants IDX_HOUR_UPPER..IDX_MINUTE_LOWER, shared with the clock block's loc encoding
- One combinational sub-module seg7_decode: 4-bit value in → 7-bit active-low pattern out.
- Counters, mux and output registers stay in seven_seg_scanner.

Test Plan:
All scenarios use SCAN_DIV=4, BLINK_DIV=8.
- Reset: assert rst 3 cycles with arbitrary inputs → an=4'b1111, seg=7'h7F, dp=1. First digit an=4'b0111 appears 1 cycle after rst release.
- Scan order: digits 1,2,3,4, setup_mode=0 → an sequence 0111,1011,1101,1110, each held 4 cycles, repeating. seg matches 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001 in turn.
- Colon: second_count=6'd10 → dp=0 only while an=4'b1011. second_count=6'd11 → dp stays 1 throughout.
- Setup blink: setup_mode=1, loc=2 → while blink_phase=1 the an=4'b1101 slot shows an=4'b1111, seg=7'h7F. Other digits unaffected. dp=1 always. Blink slot toggles every 8 cycles.
- Invalid BCD: minute_lower=4'hC → slot an=4'b1110 shows seg=7'b0111111.
- Mid-scan reset: assert rst while scan_idx=2, scan_cnt=1 → next cycle reset values. After release, an=4'b0111 is held a full 4 cycles.
